div_controller: RTL

DIV_CONTROLLER -- requirements
Module: div_controller

---
 rtl/div_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_controller.sv
// Moore control sequencer for a fetch/decode/DIV instruction: fetches through MAR/MDR/IR,
// drives both source registers out, launches the divider, then writes LO/HI or reports errors.
module div_controller (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        div_done,
   input  logic        div_by_zero,
   output logic        pco,
   output logic        mari,
   output logic        pc_inc,
   output logic        pci,
   output logic        read,
   output logic        mdri,
   output logic        mdro,
   output logic        iri,
   output logic        ryi,
   output logic        div_start,
   output logic        loi,
   output logic        hii,
   output logic [15:0] reg_out,
   output logic [15:0] reg_in,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        dz_err,
   output logic        timeout
);

   localparam logic [4:0] OP_DIV    = 5'b10000;
   localparam logic [5:0] CNT_LIMIT = 6'd31;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_WAIT, S_T6, S_T7
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [11:0] ctl_q, ctl_d;
   logic [15:0] reg_out_q, reg_out_d;
   logic        busy_q, done_q, dz_q;
   logic        is_div;
   logic        unused_ir;

   assign is_div    = (ir[31:27] == OP_DIV);
   assign unused_ir = ^ir[18:0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = is_div ? S_T4 : S_IDLE;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = S_WAIT;
         // div_done outranks the timeout, even on the final counted cycle
         S_WAIT: begin
            if (div_done)                state_d = div_by_zero ? S_T7 : S_T6;
            else if (cnt_q == CNT_LIMIT) state_d = S_IDLE;
         end
         S_T6:    state_d = S_T7;
         S_T7:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state they belong to.
   always_comb begin
      ctl_d     = '0;
      reg_out_d = '0;
      unique case (state_d)
         S_T0:    ctl_d = 12'hF00;
         S_T1:    ctl_d = 12'h0C0;
         S_T2:    ctl_d = 12'h030;
         S_T4: begin
            ctl_d     = 12'h008;
            reg_out_d = 16'h0001 << ir[26:23];
         end
         S_T5: begin
            ctl_d     = 12'h004;
            reg_out_d = 16'h0001 << ir[22:19];
         end
         S_T6:    ctl_d = 12'h003;
         default: ctl_d = '0;
      endcase
   end

   assign cnt_d = (state_q == S_WAIT) ? cnt_q + 6'd1 : '0;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ctl_q     <= '0;
         reg_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctl_q     <= ctl_d;
         reg_out_q <= reg_out_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_T7);
         dz_q      <= (state_q == S_WAIT) && div_done && div_by_zero;
      end
   end

   assign {pco, mari, pc_inc, pci, read, mdri, mdro, iri, ryi, div_start, loi, hii} = ctl_q;
   assign reg_out = reg_out_q;
   assign reg_in  = '0;
   assign busy    = busy_q;
   assign done    = done_q;
   assign dz_err  = dz_q;
   // These two pulses live in the cycle that makes the decision, so they also see ir / div_done.
   assign illegal = (state_q == S_T3) && !is_div;
   assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_LIMIT) && !div_done;

endmodule
